// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_op_sequencer                                                |
// | Purpose  : Eight-slot ALU command table. A start pulse scans the slots in  |
// |            order, issues every ready slot to a shared ALU over a req/ack   |
// |            handshake, forwards results of capture-enabled slots to the     |
// |            result stage over valid/ready, and retires each serviced slot.  |
// | Ports    : clk, rst (async, active high)                                   |
// |            w, wdata[23:0]          host slot write                         |
// |            aluop_st                run start                               |
// |            busy, done, err, issue_cnt[3:0]   run status                    |
// |            alu_req/cmd/a/b, alu_ack, alu_result   ALU handshake            |
// |            res_valid/addr/data, res_ready        result capture handshake  |
// | Slot fmt : [23]R [22]C [21:19]Addr [18:16]Cmd [15:8]a [7:0]b               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
    parameter int DEPTH       = 8,
    parameter int DW          = 8,
    parameter int RW          = 16,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w,
    input  logic [23:0]   wdata,
    input  logic          aluop_st,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [3:0]    issue_cnt,
    output logic          alu_req,
    output logic [2:0]    alu_cmd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic          alu_ack,
    input  logic [RW-1:0] alu_result,
    output logic          res_valid,
    output logic [2:0]    res_addr,
    output logic [RW-1:0] res_data,
    input  logic          res_ready
);

    // The slot format carries a fixed 3-bit address field.
    localparam int               c_AW       = 3;
    localparam logic [c_AW-1:0]  c_LAST     = c_AW'(DEPTH - 1);
    localparam logic [3:0]       c_TMO_LAST = 4'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ISSUE = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Slot table
    logic [DEPTH-1:0]  r_slot_r;
    logic [DEPTH-1:0]  r_slot_c;
    logic [2:0]        r_slot_cmd [DEPTH];
    logic [DW-1:0]     r_slot_a   [DEPTH];
    logic [DW-1:0]     r_slot_b   [DEPTH];

    // Run / operation registers
    logic [c_AW-1:0]   r_ptr;
    logic [3:0]        r_issue_cnt;
    logic              r_err;
    logic              r_op_c;
    logic [2:0]        r_cmd;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [3:0]        r_tmo;
    logic              r_dirty;
    logic [c_AW-1:0]   r_res_addr;
    logic [RW-1:0]     r_res_data;

    // Control wires
    logic              w_last;
    logic              w_wr_ptr;
    logic              w_latch;
    logic              w_retire;
    logic              w_timeout;
    logic              w_advance;

    assign w_last   = (r_ptr == c_LAST);
    assign w_wr_ptr = w && (wdata[21:19] == r_ptr);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (aluop_st) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_slot_r[r_ptr]) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_SCAN;
                end
            end
            S_ISSUE: begin
                if (alu_ack) begin
                    if (r_op_c) begin
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_retire    = 1'b1;
                        w_advance   = 1'b1;
                        w_state_nxt = w_last ? S_DONE : S_SCAN;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    // Counter would reach ALU_TIMEOUT this cycle: abandon the op.
                    w_timeout   = 1'b1;
                    w_retire    = 1'b1;
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_SCAN;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    w_retire    = 1'b1;
                    w_advance   = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot table. A host write always wins; a retire only clears R when
    // the slot has not been rewritten since its contents were latched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_r[i]   <= 1'b0;
                r_slot_c[i]   <= 1'b0;
                r_slot_cmd[i] <= '0;
                r_slot_a[i]   <= '0;
                r_slot_b[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w && (wdata[21:19] == c_AW'(i))) begin
                    r_slot_r[i]   <= wdata[23];
                    r_slot_c[i]   <= wdata[22];
                    r_slot_cmd[i] <= wdata[18:16];
                    r_slot_a[i]   <= wdata[15:8];
                    r_slot_b[i]   <= wdata[7:0];
                end else if (w_retire && !r_dirty && (r_ptr == c_AW'(i))) begin
                    r_slot_r[i]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Run datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_issue_cnt <= '0;
            r_err       <= 1'b0;
            r_op_c      <= 1'b0;
            r_cmd       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_tmo       <= '0;
            r_dirty     <= 1'b0;
            r_res_addr  <= '0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (aluop_st) begin
                        r_ptr       <= '0;
                        r_issue_cnt <= '0;
                        r_err       <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_latch) begin
                        r_op_c  <= r_slot_c[r_ptr];
                        r_cmd   <= r_slot_cmd[r_ptr];
                        r_a     <= r_slot_a[r_ptr];
                        r_b     <= r_slot_b[r_ptr];
                        r_tmo   <= '0;
                        // A write landing on the latch cycle is already newer
                        // than the copy being issued.
                        r_dirty <= w_wr_ptr;
                    end
                end
                S_ISSUE: begin
                    r_dirty <= r_dirty | w_wr_ptr;
                    if (alu_ack) begin
                        if (r_issue_cnt != 4'hF) begin
                            r_issue_cnt <= r_issue_cnt + 4'd1;
                        end
                        if (r_op_c) begin
                            r_res_data <= alu_result;
                            r_res_addr <= r_ptr;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 4'd1;
                    end
                end
                S_EMIT: begin
                    r_dirty <= r_dirty | w_wr_ptr;
                end
                default: begin
                end
            endcase

            if (w_advance && !w_last) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign issue_cnt = r_issue_cnt;
    assign alu_req   = (r_state == S_ISSUE);
    assign alu_cmd   = r_cmd;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_valid = (r_state == S_EMIT);
    assign res_addr  = r_res_addr;
    assign res_data  = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_op_sequencer                                             |
// | Purpose  : Self-checking bench for alu_op_sequencer. Expected results are  |
// |            queued when slots are written; a monitor pops and compares on   |
// |            every result transfer. An ALU responder and a capture-stage     |
// |            model drive the handshakes.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        w;
    logic [23:0] wdata;
    logic        aluop_st;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  issue_cnt;
    logic        alu_req;
    logic [2:0]  alu_cmd;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_ack;
    logic [15:0] alu_result;
    logic        res_valid;
    logic [2:0]  res_addr;
    logic [15:0] res_data;
    logic        res_ready;

    alu_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .w          (w),
        .wdata      (wdata),
        .aluop_st   (aluop_st),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issue_cnt  (issue_cnt),
        .alu_req    (alu_req),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ack    (alu_ack),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .res_data   (res_data),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ack_delay    = 0;
    int          stall_cycles = 0;
    int          last_nack_len = 0;
    int          last_vlen     = 0;
    logic [18:0] exp_q [$];

    // An operand a of 8'hEE marks an op the ALU model never acknowledges.
    localparam logic [7:0] c_NOACK = 8'hEE;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] slot(input logic r, input logic c, input logic [2:0] addr,
                                         input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b);
        return {r, c, addr, cmd, a, b};
    endfunction

    function automatic logic [15:0] alu_model(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b);
        case (cmd)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a | b};
            3'd4:    return {8'h00, a ^ b};
            3'd5:    return 16'(a) * 16'(b);
            default: return {a, b};
        endcase
    endfunction

    // ALU responder: acks ack_delay cycles into a request, records the
    // length of any request that ended without an ack.
    initial begin
        int  reqcyc;
        bit  got_ack;
        reqcyc     = 0;
        got_ack    = 1'b0;
        alu_ack    = 1'b0;
        alu_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (alu_req) begin
                if (alu_a != c_NOACK && reqcyc >= ack_delay) begin
                    alu_ack    = 1'b1;
                    alu_result = alu_model(alu_cmd, alu_a, alu_b);
                    got_ack    = 1'b1;
                end else begin
                    alu_ack = 1'b0;
                end
                reqcyc++;
            end else begin
                if (reqcyc != 0 && !got_ack) last_nack_len = reqcyc;
                reqcyc  = 0;
                got_ack = 1'b0;
                alu_ack = 1'b0;
            end
        end
    end

    // Capture stage: holds ready low for stall_cycles valid cycles.
    initial begin
        int vcnt;
        vcnt      = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                res_ready = (vcnt >= stall_cycles);
                vcnt++;
            end else begin
                vcnt      = 0;
                res_ready = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        pv;
        logic        pr;
        logic [2:0]  pa;
        logic [15:0] pd;
        logic [18:0] e;
        int          vlen;
        pv = 1'b0; pr = 1'b0; pa = '0; pd = '0; vlen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv   = 1'b0;
                vlen = 0;
            end else begin
                if (res_valid) begin
                    vlen++;
                    if (pv && !pr) begin
                        check("res_addr_stable", 32'(res_addr), 32'(pa));
                        check("res_data_stable", 32'(res_data), 32'(pd));
                    end
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_result: got addr %0d data 0x%0h, expected none",
                                     res_addr, res_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("res_addr", 32'(res_addr), 32'(e[18:16]));
                            check("res_data", 32'(res_data), 32'(e[15:0]));
                        end
                        last_vlen = vlen;
                        vlen      = 0;
                    end
                end
                pv = res_valid;
                pr = res_ready;
                pa = res_addr;
                pd = res_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic [23:0] v);
        w     = 1'b1;
        wdata = v;
        tick();
        w     = 1'b0;
    endtask

    task automatic start_pulse();
        aluop_st = 1'b1;
        cyc      = 0;
        tick();
        aluop_st = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc, input int pulse_at);
        while (!done && cyc < 400) begin
            aluop_st = (cyc == pulse_at);
            tick();
        end
        aluop_st = 1'b0;
        check({name, "_done_seen"}, 32'(done), 32'd1);
        if (exp_cyc >= 0) check({name, "_done_cycle"}, cyc, exp_cyc);
        tick();
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; w = 1'b0; wdata = '0; aluop_st = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        check("rst_alu_req",   32'(alu_req),   32'd0);
        check("rst_alu_op",    32'({alu_cmd, alu_a, alu_b}), 32'd0);
        check("rst_res",       32'({res_valid, res_addr, res_data}), 32'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of an ISSUE
        wr(slot(1'b1, 1'b1, 3'd0, 3'd0, c_NOACK, 8'h00));
        start_pulse();
        check("lat_req_cycle1", 32'(alu_req), 32'd0);
        tick();
        check("lat_req_cycle2", 32'(alu_req), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_alu_req",   32'(alu_req),   32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Empty table: done in cycle 9
        start_pulse();
        wait_done("empty", 9, -1);
        check("empty_issue_cnt", 32'(issue_cnt), 32'd0);

        // Slots 0,3,7 capture-enabled, 5+3
        wr(slot(1'b1, 1'b1, 3'd0, 3'd0, 8'd5, 8'd3));
        wr(slot(1'b1, 1'b1, 3'd3, 3'd0, 8'd5, 8'd3));
        wr(slot(1'b1, 1'b1, 3'd7, 3'd0, 8'd5, 8'd3));
        exp_q.push_back({3'd0, 16'd8});
        exp_q.push_back({3'd3, 16'd8});
        exp_q.push_back({3'd7, 16'd8});
        start_pulse();
        wait_done("three", 15, -1);
        check("three_issue_cnt", 32'(issue_cnt), 32'd3);
        check("three_err",       32'(err),       32'd0);
        check("three_q_empty",   exp_q.size(),   0);
        start_pulse();
        wait_done("three_rerun", 9, -1);
        check("three_rerun_issue_cnt", 32'(issue_cnt), 32'd0);

        // C=0 slot: issued and acked, no result
        wr(slot(1'b1, 1'b0, 3'd2, 3'd1, 8'd9, 8'd4));
        start_pulse();
        wait_done("noc", 10, -1);
        check("noc_issue_cnt", 32'(issue_cnt), 32'd1);
        start_pulse();
        wait_done("noc_rerun", 9, -1);
        check("noc_rerun_issue_cnt", 32'(issue_cnt), 32'd0);

        // Capture stage stalls 5 cycles per result
        stall_cycles = 5;
        wr(slot(1'b1, 1'b1, 3'd1, 3'd2, 8'hF0, 8'h3C));
        wr(slot(1'b1, 1'b1, 3'd2, 3'd5, 8'd12, 8'd11));
        exp_q.push_back({3'd1, 16'h0030});
        exp_q.push_back({3'd2, 16'h0084});
        start_pulse();
        wait_done("stall", 23, -1);
        check("stall_valid_len",  last_vlen,       6);
        check("stall_issue_cnt",  32'(issue_cnt),  32'd2);
        check("stall_q_empty",    exp_q.size(),    0);
        stall_cycles = 0;

        // ALU never acks slot 1; start pulse while busy is ignored
        wr(slot(1'b1, 1'b1, 3'd1, 3'd0, c_NOACK, 8'h01));
        wr(slot(1'b1, 1'b1, 3'd5, 3'd4, 8'h55, 8'h0F));
        exp_q.push_back({3'd5, 16'h005A});
        start_pulse();
        wait_done("tmo", 26, 24);
        check("tmo_req_len",   last_nack_len,   15);
        check("tmo_err",       32'(err),        32'd1);
        check("tmo_issue_cnt", 32'(issue_cnt),  32'd1);
        check("tmo_q_empty",   exp_q.size(),    0);
        start_pulse();
        wait_done("tmo_rerun", 9, -1);
        check("tmo_rerun_err", 32'(err), 32'd0);

        // Rewrite slot 4 while its op is waiting on the ALU
        ack_delay = 4;
        wr(slot(1'b1, 1'b1, 3'd4, 3'd0, 8'd1, 8'd1));
        exp_q.push_back({3'd4, 16'd2});
        start_pulse();
        while (!alu_req && cyc < 50) tick();
        check("rw_req_seen", 32'(alu_req), 32'd1);
        wr(slot(1'b1, 1'b1, 3'd4, 3'd3, 8'h81, 8'h42));
        wait_done("rw_run1", 15, -1);
        check("rw_run1_q_empty", exp_q.size(), 0);
        exp_q.push_back({3'd4, 16'h00C3});
        start_pulse();
        wait_done("rw_run2", 15, -1);
        check("rw_run2_issue_cnt", 32'(issue_cnt), 32'd1);
        check("rw_run2_q_empty",   exp_q.size(),   0);
        start_pulse();
        wait_done("rw_run3", 9, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
